// File: rtl/movement_pkg.sv
// Shared command and FSM encodings for the IR movement controller.
package movement_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_HOVER      = 4'd0;
  localparam cmd_t CMD_FWD        = 4'd1;
  localparam cmd_t CMD_BACK       = 4'd2;
  localparam cmd_t CMD_RIGHT      = 4'd3;
  localparam cmd_t CMD_LEFT       = 4'd4;
  localparam cmd_t CMD_FWD_RIGHT  = 4'd5;
  localparam cmd_t CMD_FWD_LEFT   = 4'd6;
  localparam cmd_t CMD_BACK_RIGHT = 4'd7;
  localparam cmd_t CMD_BACK_LEFT  = 4'd8;
  localparam cmd_t CMD_INVALID    = 4'd9;

  localparam logic [1:0] ST_STEADY     = 2'd0;
  localparam logic [1:0] ST_WAIT_HOLD  = 2'd1;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd2;

endpackage

// File: rtl/ir_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for a small sensor bus.
module ir_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned W               = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [W-1:0]     sync1_reg;
  logic [W-1:0]     sync2_reg;
  logic [W-1:0]     cand_reg;
  logic [W-1:0]     deb_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      cand_reg  <= '0;
      deb_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Any wobble restarts the stability window on the new value.
      if (sync2_reg != cand_reg) begin
        cand_reg <= sync2_reg;
        cnt_reg  <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (cnt_reg == CNT_MAX) begin
        deb_reg <= cand_reg;
      end
    end
  end

  assign deb = deb_reg;

endmodule

// File: rtl/movement_controller.sv
// Turns debounced IR gestures into a held movement command, committed only at frame starts.
module movement_controller
  import movement_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MIN_HOLD_CYCLES = 5000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ir_raw,
  input  logic       frame_start,
  output logic [3:0] ir_disp,
  output logic [3:0] cmd,
  output logic       cmd_changed,
  output logic       fault
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD_CYCLES);

  logic [3:0]       deb;
  cmd_t             nxt;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  cmd_t             pend_cmd_reg;
  logic [3:0]       pend_ir_reg;
  cmd_t             cmd_reg;
  logic [3:0]       ir_disp_reg;
  logic             changed_reg;
  logic             fault_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             hold_done;
  logic             pend_load;
  logic             commit;
  cmd_t             commit_cmd;
  logic [3:0]       commit_ir;

  ir_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .W              (4)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (ir_raw),
    .deb  (deb)
  );

  // Bits: [0]=back [1]=fwd [2]=right [3]=left; opposing pairs are contradictory.
  always_comb begin
    nxt = CMD_HOVER;
    if ((deb[0] && deb[1]) || (deb[2] && deb[3])) nxt = CMD_INVALID;
    else if (deb[2] && deb[1])                    nxt = CMD_FWD_RIGHT;
    else if (deb[3] && deb[1])                    nxt = CMD_FWD_LEFT;
    else if (deb[2] && deb[0])                    nxt = CMD_BACK_RIGHT;
    else if (deb[3] && deb[0])                    nxt = CMD_BACK_LEFT;
    else if (deb[0])                              nxt = CMD_BACK;
    else if (deb[1])                              nxt = CMD_FWD;
    else if (deb[2])                              nxt = CMD_RIGHT;
    else if (deb[3])                              nxt = CMD_LEFT;
  end

  assign hold_done = (hold_cnt_reg == HOLD_MAX);

  always_comb begin
    state_next = state_reg;
    pend_load  = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      ST_STEADY: begin
        if (nxt != cmd_reg) begin
          if (hold_done) begin
            pend_load  = 1'b1;
            state_next = ST_WAIT_FRAME;
          end else begin
            state_next = ST_WAIT_HOLD;
          end
        end
      end
      ST_WAIT_HOLD: begin
        if (nxt == cmd_reg) begin
          state_next = ST_STEADY;
        end else if (hold_done) begin
          pend_load  = 1'b1;
          state_next = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (nxt == cmd_reg) begin
          state_next = ST_STEADY;
        end else begin
          pend_load = (nxt != pend_cmd_reg);
          if (frame_start) begin
            commit     = 1'b1;
            state_next = ST_STEADY;
          end
        end
      end
      default: state_next = ST_STEADY;
    endcase
  end

  // A re-latch coinciding with the frame pulse commits the newest value.
  assign commit_cmd = pend_load ? nxt : pend_cmd_reg;
  assign commit_ir  = pend_load ? deb : pend_ir_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_STEADY;
      pend_cmd_reg <= CMD_HOVER;
      pend_ir_reg  <= '0;
      cmd_reg      <= CMD_HOVER;
      ir_disp_reg  <= '0;
      changed_reg  <= 1'b0;
      fault_reg    <= 1'b0;
      hold_cnt_reg <= HOLD_MAX;
    end else begin
      state_reg   <= state_next;
      changed_reg <= commit;
      if (pend_load) begin
        pend_cmd_reg <= nxt;
        pend_ir_reg  <= deb;
      end
      if (commit) begin
        cmd_reg      <= commit_cmd;
        ir_disp_reg  <= commit_ir;
        fault_reg    <= (commit_cmd == CMD_INVALID);
        hold_cnt_reg <= '0;
      end else if (!hold_done) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
    end
  end

  assign cmd         = cmd_reg;
  assign ir_disp     = ir_disp_reg;
  assign cmd_changed = changed_reg;
  assign fault       = fault_reg;

endmodule

// File: tb/tb_movement_controller.sv
// Directed bench for movement_controller with a cycle-level behavioural reference model.
module tb_movement_controller;

  localparam int D = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ir_raw;
  logic       frame_start;
  logic [3:0] ir_disp;
  logic [3:0] cmd;
  logic       cmd_changed;
  logic       fault;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int cycle  = 0;
  int period = 16;
  int fcnt   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  movement_controller #(
    .DEBOUNCE_CYCLES(D),
    .MIN_HOLD_CYCLES(H),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir_raw     (ir_raw),
    .frame_start(frame_start),
    .ir_disp    (ir_disp),
    .cmd        (cmd),
    .cmd_changed(cmd_changed),
    .fault      (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Command as a grid: vertical axis (none/fwd/back) x horizontal axis (none/right/left).
  function automatic logic [3:0] model_cmd(input logic [3:0] ir);
    int v;
    int hz;
    if ((ir[0] && ir[1]) || (ir[2] && ir[3])) return 4'd9;
    v  = ir[1] ? 1 : (ir[0] ? 2 : 0);
    hz = ir[2] ? 1 : (ir[3] ? 2 : 0);
    if (hz == 0) return 4'(v);
    if (v == 0) return 4'(2 + hz);
    return 4'(2 * v + hz + 2);
  endfunction

  // Reference model: raw samples history, debounced value, armed/pending request, hold age.
  logic [3:0] hist [0:D+3];
  logic [3:0] m_deb, m_cmd, m_ir, p_cmd, p_ir, want;
  bit         m_fault, m_chg, armed, all_eq;
  int         age;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < D + 4; i++) hist[i] = 4'd0;
      m_deb = 0; m_cmd = 0; m_ir = 0; p_cmd = 0; p_ir = 0;
      m_fault = 0; m_chg = 0; armed = 0; age = H;
    end else begin
      want  = model_cmd(m_deb);
      m_chg = 0;
      if (want == m_cmd) begin
        armed = 0;
      end else if (armed) begin
        if (want != p_cmd) begin
          p_cmd = want;
          p_ir  = m_deb;
        end
        if (frame_start) begin
          m_cmd   = p_cmd;
          m_ir    = p_ir;
          m_fault = (p_cmd == 4'd9);
          m_chg   = 1;
          armed   = 0;
        end
      end else if (age >= H) begin
        armed = 1;
        p_cmd = want;
        p_ir  = m_deb;
      end
      if (m_chg) age = 0;
      else if (age < H) age++;
      for (int i = D + 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ir_raw;
      // The value seen three edges ago must have been sampled D+1 times in a row.
      all_eq = 1;
      for (int i = 4; i <= D + 3; i++) if (hist[i] != hist[3]) all_eq = 0;
      if (all_eq) m_deb = hist[3];
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en && rst_n) begin
      chk("cyc_cmd", cmd, m_cmd);
      chk("cyc_ir_disp", ir_disp, m_ir);
      chk("cyc_cmd_changed", cmd_changed, m_chg);
      chk("cyc_fault", fault, m_fault);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && cmd_changed === 1'b1) begin
      pulses++;
      $display("commit %0d: cmd=%0d ir_disp=%b fault=%0d cycle=%0d", pulses, cmd, ir_disp, fault, cycle);
    end
  end

  task automatic step(input bit force_fs = 1'b0);
    @(negedge clk);
    cycle++;
    if (period != 0) fcnt = (fcnt + 1) % period;
    frame_start = force_fs || (period != 0 && fcnt == 0);
  endtask

  task automatic wait_changed(input string name, input int budget);
    int n = 0;
    step();
    while (cmd_changed !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, {31'd0, cmd_changed === 1'b1}, 32'd1);
  endtask

  logic [3:0] seq [0:11] = '{4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b0001, 4'b0101,
                             4'b1001, 4'b1100, 4'b0000, 4'b1010, 4'b0011, 4'b0100};
  int p0;
  int c1;

  initial begin
    ir_raw = 4'd0;
    frame_start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("reset_cmd", cmd, 0);
    chk("reset_ir_disp", ir_disp, 0);
    chk("reset_fault", fault, 0);
    chk("reset_cmd_changed", cmd_changed, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Glitch shorter than the debounce window
    p0 = pulses;
    ir_raw = 4'b0010;
    repeat (3) step();
    ir_raw = 4'b0000;
    repeat (40) step();
    chk("glitch_no_pulse", pulses - p0, 0);
    chk("glitch_cmd", cmd, 0);

    // Forward held
    p0 = pulses;
    ir_raw = 4'b0010;
    wait_changed("fwd", 60);
    chk("fwd_cmd", cmd, 1);
    chk("fwd_ir_disp", ir_disp, 4'b0010);
    chk("fwd_fault", fault, 0);
    repeat (30) step();
    chk("fwd_single_pulse", pulses - p0, 1);

    // Diagonal, then the opposite diagonal shortly after
    ir_raw = 4'b0110;
    wait_changed("fr", 60);
    chk("fr_cmd", cmd, 5);
    chk("fr_ir_disp", ir_disp, 4'b0110);
    c1 = cycle;
    repeat (2) step();
    ir_raw = 4'b1010;
    wait_changed("fl", 80);
    chk("fl_cmd", cmd, 6);
    chk("fl_ir_disp", ir_disp, 4'b1010);
    chk("fl_hold_gap", {31'd0, (cycle - c1) >= H}, 1);

    // Contradictory input raises fault, clearing it returns to hover
    repeat (20) step();
    ir_raw = 4'b0011;
    wait_changed("inv", 60);
    chk("inv_cmd", cmd, 9);
    chk("inv_fault", fault, 1);
    chk("inv_ir_disp", ir_disp, 4'b0011);
    repeat (20) step();
    ir_raw = 4'b0000;
    wait_changed("clr", 60);
    chk("clr_cmd", cmd, 0);
    chk("clr_fault", fault, 0);

    // Fast frames with rapid input changes so the hold time actually binds
    p0 = pulses;
    period = 3;
    for (int i = 0; i < 12; i++) begin
      ir_raw = seq[i];
      repeat (6) step();
    end
    for (int i = 0; i < 12; i++) begin
      ir_raw = seq[11 - i];
      repeat (12) step();
    end
    ir_raw = 4'b0000;
    period = 16;
    repeat (60) step();
    chk("fast_activity", {31'd0, (pulses - p0) > 0}, 1);
    chk("fast_end_cmd", cmd, 0);

    // Pending FWD abandoned before any frame
    period = 0;
    repeat (20) step();
    p0 = pulses;
    ir_raw = 4'b0010;
    repeat (12) step();
    ir_raw = 4'b0000;
    repeat (14) step();
    period = 16;
    repeat (40) step();
    chk("revert_no_pulse", pulses - p0, 0);
    chk("revert_cmd", cmd, 0);

    // Frame pulse on the very cycle the request arms must not commit
    period = 0;
    repeat (20) step();
    p0 = pulses;
    ir_raw = 4'b0001;
    repeat (7) step();
    step(1'b1);
    repeat (10) step();
    chk("entry_no_pulse", pulses - p0, 0);
    chk("entry_cmd", cmd, 0);
    step(1'b1);
    step();
    chk("entry_late_cmd", cmd, 2);
    chk("entry_late_ir_disp", ir_disp, 4'b0001);
    step();
    chk("entry_late_pulse", pulses - p0, 1);

    // Asynchronous reset with a request pending
    ir_raw = 4'b0100;
    repeat (12) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_cmd", cmd, 0);
    chk("async_ir_disp", ir_disp, 0);
    chk("async_fault", fault, 0);
    chk("async_cmd_changed", cmd_changed, 0);
    ir_raw = 4'b0000;
    repeat (2) step();
    rst_n = 1'b1;
    p0 = pulses;
    period = 16;
    repeat (40) step();
    chk("async_no_pulse", pulses - p0, 0);
    chk("async_end_cmd", cmd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
